// File: rtl/btn_led_sequencer.sv
// Button-driven LED bank sequencer: debounces four buttons, queues presses and
// shows each requesting group's switch nibble on its LEDs in round-robin order.
module btn_led_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic [3:0]  btn,
    output logic [15:0] led,
    output logic [3:0]  grant,
    output logic [3:0]  pending,
    output logic        busy
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, btn_s, deb, deb_d, rise, clr;
    logic [CW-1:0] cnt [4];
    logic [HW-1:0] hold_cnt;
    logic [1:0]    rr_ptr, cur, win_idx;
    logic          win_valid, show_done;

    // Two-flop synchronizer followed by a per-button stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            btn_s <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (btn_s[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise      = deb & ~deb_d;
    assign show_done = (state == SHOW) && (hold_cnt == '0);
    assign clr       = show_done ? (4'b0001 << cur) : 4'b0000;

    // Round-robin pick: lowest offset from rr_ptr wins, so scan offsets high to low
    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (pending[2'(rr_ptr + 2'(k))]) begin
                win_valid = 1'b1;
                win_idx   = 2'(rr_ptr + 2'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (win_valid) state_n = SHOW;
            SHOW:    if (hold_cnt == '0) state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        led  = '0;
        busy = (state == SHOW) || (state == GAP);
        if (state == SHOW) begin
            for (int i = 0; i < 4; i++) begin
                if (grant[i]) led[4*i +: 4] = sw[4*i +: 4];
            end
        end
    end

    // Request queue, grant and hold timer; a press landing on the clearing edge survives
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            grant    <= '0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
            cur      <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant    <= 4'b0001 << win_idx;
                        cur      <= win_idx;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                SHOW: begin
                    if (show_done) begin
                        grant  <= '0;
                        rr_ptr <= cur + 2'd1;
                    end else if (rise[cur]) begin
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_led_sequencer.sv
// Directed bench for btn_led_sequencer: expected grants are queued when buttons
// are pressed and compared when the DUT raises grant.
module tb_btn_led_sequencer;

    localparam int unsigned HOLD = 8;

    typedef struct {
        logic [3:0]  grant;
        logic [15:0] led;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [3:0]  btn;
    logic [15:0] led;
    logic [3:0]  grant;
    logic [3:0]  pending;
    logic        busy;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          waited;
    logic [3:0]  cur_grant;
    logic [3:0]  any_g;

    btn_led_sequencer #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn),
        .led(led), .grant(grant), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [15:0] l);
        exp_t e;
        e.grant = g;
        e.led   = l;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a grant, then compare it against the oldest expectation
    task automatic start_show();
        exp_t e;
        waited = 0;
        while (waited < 60) begin
            @(negedge clk);
            waited++;
            if (grant != 4'b0000) break;
        end
        check("grant_seen", 32'(grant != 4'b0000), 32'd1);
        if (sb.size() == 0) begin
            check("sb_has_entry", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("show_grant", 32'(grant), 32'(e.grant));
            check("show_led", 32'(led), 32'(e.led));
        end
        cur_grant = grant;
    endtask

    task automatic end_show(input int elapsed, input int exp_len);
        int len;
        len = elapsed;
        while (len < 100) begin
            @(negedge clk);
            if (grant != cur_grant) break;
            len++;
        end
        check("show_len", 32'(len), 32'(exp_len));
        check("gap_grant", 32'(grant), 32'd0);
        check("gap_led", 32'(led), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic serve();
        start_show();
        end_show(1, HOLD);
    endtask

    initial begin
        rst = 1'b1;
        btn = 4'hF;
        sw  = 16'hFFFF;

        // Reset holds everything quiet even with all buttons pressed
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check("rst_led", 32'(led), 32'd0);
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_pending", 32'(pending), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        push(4'b0001, 16'h000F);
        push(4'b0010, 16'h00F0);
        push(4'b0100, 16'h0F00);
        push(4'b1000, 16'hF000);
        repeat (4) serve();
        btn = 4'h0;
        tick(10);
        check("t1_pending", 32'(pending), 32'd0);

        // Single press: pending appears on the 7th edge after the button rises
        btn = 4'b0001;
        push(4'b0001, 16'h000F);
        tick(6);
        check("t2_pending_early", 32'(pending), 32'd0);
        tick(1);
        check("t2_pending", 32'(pending), 32'b0001);
        check("t2_grant_idle", 32'(grant), 32'd0);
        serve();
        check("t2_pending_clr", 32'(pending), 32'd0);
        btn = 4'b0000;
        tick(8);

        // Bouncing button never produces a request
        for (int t = 0; t < 6; t++) begin
            btn[2] = ~btn[2];
            tick(2);
            check("t3_bounce_pending", 32'(pending), 32'd0);
        end
        btn = 4'b0000;
        tick(8);
        check("t3_pending", 32'(pending), 32'd0);
        check("t3_led", 32'(led), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("pre4_pending", 32'(pending), 32'd0);
        check("pre4_grant", 32'(grant), 32'd0);

        // Simultaneous presses from rr_ptr=0
        sw  = 16'hA5A5;
        btn = 4'b0101;
        push(4'b0001, 16'h0005);
        push(4'b0100, 16'h0500);
        start_show();
        end_show(1, HOLD);
        start_show();
        check("t4_back_to_back", 32'(waited), 32'd1);
        end_show(1, HOLD);
        btn = 4'b0000;
        check("t4_pending", 32'(pending), 32'd0);
        tick(8);

        // Fairness after group0 and live switch tracking
        sw  = 16'hAAAA;
        btn = 4'b0001;
        push(4'b0001, 16'h000A);
        serve();
        btn = 4'b0000;
        tick(8);
        btn = 4'b0011;
        push(4'b0010, 16'h00A0);
        push(4'b0001, 16'h000F);
        start_show();
        check("t5_pending_both", 32'(pending), 32'b0011);
        tick(1);
        sw = 16'h0F0F;
        tick(1);
        check("t5_live_led", 32'(led), 32'd0);
        end_show(3, HOLD);
        start_show();
        end_show(1, HOLD);
        btn = 4'b0000;
        check("t5_pending", 32'(pending), 32'd0);
        tick(8);

        // Reset in the middle of group3's display with group1 queued
        sw  = 16'hFFFF;
        btn = 4'b1000;
        push(4'b1000, 16'hF000);
        tick(2);
        btn = 4'b1010;
        start_show();
        tick(3);
        check("t6_pending", 32'(pending), 32'b1010);
        rst = 1'b1;
        btn = 4'b0000;
        tick(1);
        rst = 1'b0;
        check("t6_led", 32'(led), 32'd0);
        check("t6_grant", 32'(grant), 32'd0);
        check("t6_pending_rst", 32'(pending), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        any_g = 4'b0000;
        repeat (20) begin
            tick(1);
            any_g = any_g | grant;
        end
        check("t6_no_resume", 32'(any_g), 32'd0);

        // rr_ptr is back at 0 after reset
        btn = 4'b0011;
        push(4'b0001, 16'h000F);
        push(4'b0010, 16'h00F0);
        serve();
        serve();
        btn = 4'b0000;
        check("final_pending", 32'(pending), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
